// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the CPU/DMA data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_t;

  localparam int DEF_ABITS       = 32;
  localparam int DEF_DBITS       = 32;
  localparam int DEF_MAX_BURST   = 16;
  localparam int DEF_CPU_QUANTUM = 4;
  localparam int STALL_W         = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU pins, the DMA master pins and the data-memory port seen by the arbiter.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int Abits = DEF_ABITS,
  parameter int Dbits = DEF_DBITS
) ();

  logic               run_en;
  logic               cpu_enable;
  logic               cpu_mem_wr;
  logic [Abits-1:0]   cpu_mem_addr;
  logic [Dbits-1:0]   cpu_mem_wdata;
  logic [Dbits-1:0]   cpu_mem_rdata;
  logic               dma_req;
  logic               dma_wr;
  logic               dma_last;
  logic [Abits-1:0]   dma_addr;
  logic [Dbits-1:0]   dma_wdata;
  logic               dma_gnt;
  logic [Dbits-1:0]   dma_rdata;
  logic               mem_wr;
  logic [Abits-1:0]   mem_addr;
  logic [Dbits-1:0]   mem_wdata;
  logic [Dbits-1:0]   mem_rdata;
  logic [STALL_W-1:0] stall_cycles;

  // Arbiter side.
  modport slave (
    input  run_en, cpu_mem_wr, cpu_mem_addr, cpu_mem_wdata,
           dma_req, dma_wr, dma_last, dma_addr, dma_wdata, mem_rdata,
    output cpu_enable, cpu_mem_rdata, dma_gnt, dma_rdata,
           mem_wr, mem_addr, mem_wdata, stall_cycles
  );

  // CPU, DMA engine and memory side.
  modport master (
    output run_en, cpu_mem_wr, cpu_mem_addr, cpu_mem_wdata,
           dma_req, dma_wr, dma_last, dma_addr, dma_wdata, mem_rdata,
    input  cpu_enable, cpu_mem_rdata, dma_gnt, dma_rdata,
           mem_wr, mem_addr, mem_wdata, stall_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; a clear takes priority over an increment.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o,
  output logic         sat_o
);

  logic [W-1:0] count_q, count_d;

  assign sat_o = (count_q == MAX);
  assign q_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !sat_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the data-memory port between the CPU and a DMA master; the CPU is frozen while DMA owns memory.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int CPU_QUANTUM = DEF_CPU_QUANTUM
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int QW = $clog2(CPU_QUANTUM + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t         state_q, state_d;
  logic [QW-1:0]      qcnt;
  logic [BW-1:0]      bcnt;
  logic [STALL_W-1:0] stallCnt;
  logic               quantumMet, burstFull, stallSat;
  logic               cpuRun, beat, dmaExit;
  logic               unusedCnt;

  assign cpuRun  = (state_q == S_CPU) && bus.run_en && !reset;
  assign beat    = (state_q == S_DMA) && bus.dma_req;
  // burstFull means the beat in flight is the last one this grant may take.
  assign dmaExit = !bus.dma_req || bus.dma_last || burstFull;

  sat_counter #(.W(QW), .MAX(QW'(CPU_QUANTUM))) u_qcnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (cpuRun),
    .clr_i (state_q == S_DMA),
    .q_o   (qcnt),
    .sat_o (quantumMet)
  );

  sat_counter #(.W(BW), .MAX(BW'(MAX_BURST - 1))) u_bcnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (beat),
    .clr_i (state_q == S_CPU),
    .q_o   (bcnt),
    .sat_o (burstFull)
  );

  sat_counter #(.W(STALL_W), .MAX('1)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc_i ((state_q == S_DMA) && bus.run_en),
    .clr_i (1'b0),
    .q_o   (stallCnt),
    .sat_o (stallSat)
  );

  assign unusedCnt = ^{qcnt, bcnt, stallSat};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CPU: if (bus.dma_req && quantumMet) state_d = S_DMA;
      S_DMA: if (dmaExit) state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
  end

  // Reset forces every strobe low so a burst cut by reset never writes a partial beat.
  always_comb begin
    bus.cpu_enable = 1'b0;
    bus.dma_gnt    = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = bus.cpu_mem_addr;
    bus.mem_wdata  = bus.cpu_mem_wdata;
    if (state_q == S_DMA) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      if (!reset) begin
        bus.dma_gnt = 1'b1;
        bus.mem_wr  = bus.dma_req && bus.dma_wr;
      end
    end else begin
      bus.cpu_enable = cpuRun;
      bus.mem_wr     = bus.cpu_mem_wr && cpuRun;
    end
  end

  assign bus.cpu_mem_rdata = bus.mem_rdata;
  assign bus.dma_rdata     = bus.mem_rdata;
  assign bus.stall_cycles  = stallCnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Checks two arbiter configurations (16/4 and 1/1) against a cycle-level ownership model.
module tb_mem_arbiter;

  typedef struct {
    bit          owns;
    int          cpuCycles;
    int          beats;
    longint      stall;
  } model_t;

  typedef struct {
    bit r, ru, cw, rq, dw, dl;
    bit eEn, eGnt, eWr;
    int eSel;
    int eStall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, run, cpuWr, dmaReq, dmaWr, dmaLast;
  logic [31:0] cpuAddr, cpuWdata, dmaAddr, dmaWdata, memRdata;
  int          vecCount = 0;
  int          missCount = 0;
  model_t      mA, mB;
  vec_t        vecs [18];

  always #5 clk = ~clk;

  mem_arbiter_if busA ();
  mem_arbiter_if busB ();

  assign busA.run_en        = run;
  assign busA.cpu_mem_wr    = cpuWr;
  assign busA.cpu_mem_addr  = cpuAddr;
  assign busA.cpu_mem_wdata = cpuWdata;
  assign busA.dma_req       = dmaReq;
  assign busA.dma_wr        = dmaWr;
  assign busA.dma_last      = dmaLast;
  assign busA.dma_addr      = dmaAddr;
  assign busA.dma_wdata     = dmaWdata;
  assign busA.mem_rdata     = memRdata;

  assign busB.run_en        = run;
  assign busB.cpu_mem_wr    = cpuWr;
  assign busB.cpu_mem_addr  = cpuAddr;
  assign busB.cpu_mem_wdata = cpuWdata;
  assign busB.dma_req       = dmaReq;
  assign busB.dma_wr        = dmaWr;
  assign busB.dma_last      = dmaLast;
  assign busB.dma_addr      = dmaAddr;
  assign busB.dma_wdata     = dmaWdata;
  assign busB.mem_rdata     = memRdata;

  mem_arbiter #(.MAX_BURST(16), .CPU_QUANTUM(4)) dutA (.clk(clk), .reset(rst), .bus(busA));
  mem_arbiter #(.MAX_BURST(1),  .CPU_QUANTUM(1)) dutB (.clk(clk), .reset(rst), .bus(busB));

  // Ownership model: who holds memory, how many enabled CPU cycles since the last grant,
  // how many beats in the current grant.
  function automatic model_t nextModel(model_t m, int quantum, int maxBurst);
    model_t n = m;
    bit     leave = 1'b0;
    if (rst) begin
      n.owns = 1'b0; n.cpuCycles = 0; n.beats = 0; n.stall = 0;
    end else if (!m.owns) begin
      if (run) n.cpuCycles = m.cpuCycles + 1;
      if (dmaReq && m.cpuCycles >= quantum) begin
        n.owns = 1'b1; n.beats = 0;
      end
    end else begin
      if (run && m.stall < 64'h0000_0000_FFFF_FFFF) n.stall = m.stall + 1;
      if (!dmaReq) leave = 1'b1;
      else begin
        n.beats = m.beats + 1;
        if (dmaLast || n.beats >= maxBurst) leave = 1'b1;
      end
      if (leave) begin
        n.owns = 1'b0; n.cpuCycles = 0;
      end
    end
    return n;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOne(string tag, model_t m, logic en, logic gnt, logic wr,
                          logic [31:0] addr, logic [31:0] wdata,
                          logic [31:0] crd, logic [31:0] drd, logic [31:0] stall);
    bit eEn  = !rst && !m.owns && run;
    bit eGnt = !rst && m.owns;
    bit eWr  = !rst && (m.owns ? (dmaReq && dmaWr) : (cpuWr && run));
    cmp({tag, ".cpu_enable"}, 64'(en), 64'(eEn));
    cmp({tag, ".dma_gnt"}, 64'(gnt), 64'(eGnt));
    cmp({tag, ".mem_wr"}, 64'(wr), 64'(eWr));
    if (!rst) begin
      cmp({tag, ".mem_addr"}, 64'(addr), 64'(m.owns ? dmaAddr : cpuAddr));
      cmp({tag, ".mem_wdata"}, 64'(wdata), 64'(m.owns ? dmaWdata : cpuWdata));
    end
    cmp({tag, ".cpu_mem_rdata"}, 64'(crd), 64'(memRdata));
    cmp({tag, ".dma_rdata"}, 64'(drd), 64'(memRdata));
    cmp({tag, ".stall_cycles"}, 64'(stall), m.stall);
  endtask

  task automatic checkOutput();
    checkOne("A", mA, busA.cpu_enable, busA.dma_gnt, busA.mem_wr, busA.mem_addr,
             busA.mem_wdata, busA.cpu_mem_rdata, busA.dma_rdata, busA.stall_cycles);
    checkOne("B", mB, busB.cpu_enable, busB.dma_gnt, busB.mem_wr, busB.mem_addr,
             busB.mem_wdata, busB.cpu_mem_rdata, busB.dma_rdata, busB.stall_cycles);
  endtask

  task automatic applyStimulus(bit r, bit ru, bit cw, bit rq, bit dw, bit dl);
    rst = r; run = ru; cpuWr = cw; dmaReq = rq; dmaWr = dw; dmaLast = dl;
    cpuAddr = $urandom; cpuWdata = $urandom; dmaAddr = $urandom;
    dmaWdata = $urandom; memRdata = $urandom;
    @(negedge clk);
  endtask

  task automatic endCycle();
    @(posedge clk);
    mA = nextModel(mA, 4, 16);
    mB = nextModel(mB, 1, 1);
    #1;
  endtask

  task automatic step(bit r, bit ru, bit cw, bit rq, bit dw, bit dl);
    applyStimulus(r, ru, cw, rq, dw, dl);
    checkOutput();
    endCycle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int runA, runB, cpuWinA, burstsA, grants, waitCycles;
    vecs = '{
      '{1,1,1,1,1,0, 0,0,0, 2,0}, '{1,1,0,0,0,0, 0,0,0, 2,0},
      '{0,1,1,0,0,0, 1,0,1, 0,0}, '{0,1,0,1,1,0, 1,0,0, 0,0},
      '{0,1,1,1,1,0, 1,0,1, 0,0}, '{0,1,0,1,0,0, 1,0,0, 0,0},
      '{0,1,1,1,1,0, 1,0,1, 0,0}, '{0,1,1,1,1,0, 0,1,1, 1,0},
      '{0,1,1,1,0,0, 0,1,0, 1,1}, '{0,1,0,1,1,1, 0,1,1, 1,2},
      '{0,1,0,1,1,0, 1,0,0, 0,3}, '{0,1,1,1,1,0, 1,0,1, 0,3},
      '{0,1,0,1,1,0, 1,0,0, 0,3}, '{0,0,1,1,1,0, 0,0,0, 0,3},
      '{0,1,0,1,1,0, 1,0,0, 0,3}, '{0,1,0,1,1,0, 1,0,0, 0,3},
      '{0,1,1,0,1,0, 0,1,0, 1,3}, '{0,1,1,0,0,0, 1,0,1, 0,4}
    };

    rst = 1'b1; run = 1'b1; cpuWr = 1'b0; dmaReq = 1'b0; dmaWr = 1'b0; dmaLast = 1'b0;
    cpuAddr = '0; cpuWdata = '0; dmaAddr = '0; dmaWdata = '0; memRdata = '0;
    repeat (2) @(posedge clk);
    #1;
    mA = '{owns: 1'b0, cpuCycles: 0, beats: 0, stall: 0};
    mB = mA;

    // Reset, quantum, three-beat transfer, CPU store blocked in DMA, frozen CPU, empty grant.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].r, vecs[i].ru, vecs[i].cw, vecs[i].rq, vecs[i].dw, vecs[i].dl);
      checkOutput();
      cmp($sformatf("vec%0d.cpu_enable", i), 64'(busA.cpu_enable), 64'(vecs[i].eEn));
      cmp($sformatf("vec%0d.dma_gnt", i), 64'(busA.dma_gnt), 64'(vecs[i].eGnt));
      cmp($sformatf("vec%0d.mem_wr", i), 64'(busA.mem_wr), 64'(vecs[i].eWr));
      if (vecs[i].eSel != 2)
        cmp($sformatf("vec%0d.mem_addr", i), 64'(busA.mem_addr),
            64'(vecs[i].eSel == 1 ? dmaAddr : cpuAddr));
      cmp($sformatf("vec%0d.stall", i), 64'(busA.stall_cycles), 64'(vecs[i].eStall));
      endCycle();
    end

    // Held request without dma_last: 16-beat bursts separated by CPU windows.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    runA = 0; runB = 0; cpuWinA = 0; burstsA = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(0, 1, 1'($urandom), 1, 1'($urandom), 0);
      checkOutput();
      if (busA.dma_gnt) begin
        if (runA == 0) cmp("A.cpu_window", 64'(cpuWinA), 64'd5);
        runA++;
        cpuWinA = 0;
      end else begin
        if (runA > 0) begin
          burstsA++;
          cmp("A.burst_len", 64'(runA), 64'd16);
          cmp("A.burst_stall", 64'(busA.stall_cycles), 64'(16 * burstsA));
        end
        runA = 0;
        cpuWinA++;
      end
      if (busB.dma_gnt) runB++;
      else begin
        if (runB > 0) cmp("B.burst_len", 64'(runB), 64'd1);
        runB = 0;
      end
      endCycle();
    end
    cmp("A.bursts_seen", 64'(burstsA), 64'd4);

    // Quantum met, then run_en drops: DMA is still granted and stall does not count.
    step(1, 1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkOutput();
    cmp("frozen.cpu_enable", 64'(busA.cpu_enable), 64'd0);
    cmp("frozen.pre_gnt", 64'(busA.dma_gnt), 64'd0);
    endCycle();
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkOutput();
    cmp("frozen.gnt", 64'(busA.dma_gnt), 64'd1);
    cmp("frozen.mem_wr", 64'(busA.mem_wr), 64'd1);
    endCycle();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput();
    cmp("frozen.stall", 64'(busA.stall_cycles), 64'd0);
    endCycle();

    // Quantum not met and run_en low: DMA waits.
    step(1, 1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    grants = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, 0, 1'($urandom), 1, 1, 0);
      checkOutput();
      if (busA.dma_gnt) grants++;
      endCycle();
    end
    cmp("starved.grants", 64'(grants), 64'd0);

    // Reset on the second beat of a burst.
    step(1, 1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    applyStimulus(1, 1, 1, 1, 1, 0);
    checkOutput();
    cmp("rst_beat.mem_wr", 64'(busA.mem_wr), 64'd0);
    cmp("rst_beat.gnt", 64'(busA.dma_gnt), 64'd0);
    endCycle();
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput();
    cmp("after_rst.gnt", 64'(busA.dma_gnt), 64'd0);
    cmp("after_rst.cpu_enable", 64'(busA.cpu_enable), 64'd1);
    cmp("after_rst.stall", 64'(busA.stall_cycles), 64'd0);
    waitCycles = 0;
    while (!busA.dma_gnt && waitCycles < 20) begin
      endCycle();
      applyStimulus(0, 1, 0, 1, 1, 0);
      checkOutput();
      waitCycles++;
    end
    cmp("after_rst.requantum", 64'(waitCycles), 64'd5);
    endCycle();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
